control_unit: RTL

- Instruction sequencer for the 4-bit CPU.
- Steps each instruction through fetch, decode and execute states.
- Drives the program counter controls (`ir_load_en`, `halt`, `jump_en`, `jump_addr`) and the accumulator/ALU/output-register strobes.
- Sits between the instruction register output and the counter, ALU, data memory and output register; it is the only master of those enables.

---
 rtl/control_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Three-phase instruction sequencer for the 4-bit CPU. It
//               drives PC, IR, data memory, accumulator/ALU and output strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int OPW = 4,
    parameter int ADW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OPW+ADW-1:0] instr,
    input  logic               zero_flag,
    input  logic               carry_flag,
    output logic               ir_load_en,
    output logic               halt,
    output logic               jump_en,
    output logic [ADW-1:0]     jump_addr,
    output logic               data_rd_en,
    output logic [ADW-1:0]     data_addr,
    output logic               acc_load_en,
    output logic [1:0]         acc_src,
    output logic [1:0]         alu_op,
    output logic               out_load_en,
    output logic [7:0]         instr_count,
    output logic [1:0]         state_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    localparam logic [OPW-1:0] c_op_nop = OPW'(4'h0);
    localparam logic [OPW-1:0] c_op_lda = OPW'(4'h1);
    localparam logic [OPW-1:0] c_op_add = OPW'(4'h2);
    localparam logic [OPW-1:0] c_op_sub = OPW'(4'h3);
    localparam logic [OPW-1:0] c_op_out = OPW'(4'h4);
    localparam logic [OPW-1:0] c_op_jmp = OPW'(4'h5);
    localparam logic [OPW-1:0] c_op_jz  = OPW'(4'h6);
    localparam logic [OPW-1:0] c_op_jc  = OPW'(4'h7);
    localparam logic [OPW-1:0] c_op_ldi = OPW'(4'h8);
    localparam logic [OPW-1:0] c_op_hlt = OPW'(4'hF);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_halted;
    logic [7:0]      r_instr_count;
    logic [OPW-1:0]  w_opcode;
    logic [ADW-1:0]  w_operand;
    logic            w_is_mem_op;

    assign w_opcode    = instr[OPW+ADW-1:ADW];
    assign w_operand   = instr[ADW-1:0];
    assign w_is_mem_op = (w_opcode == c_op_lda) || (w_opcode == c_op_add) ||
                         (w_opcode == c_op_sub);

    assign instr_count = r_instr_count;
    assign state_out   = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_halted      <= 1'b0;
            r_instr_count <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_EXEC) begin
                r_instr_count <= r_instr_count + 8'd1;
                if (w_opcode == c_op_hlt) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:   if (start && !r_halted) w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = ST_EXEC;
            ST_EXEC:   w_next_state = (w_opcode == c_op_hlt) ? ST_IDLE : ST_FETCH;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // The PC may only advance on the FETCH edge, so halt is asserted elsewhere.
    always_comb begin
        ir_load_en  = 1'b0;
        halt        = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = '0;
        data_rd_en  = 1'b0;
        data_addr   = '0;
        acc_load_en = 1'b0;
        acc_src     = 2'd0;
        alu_op      = 2'd0;
        out_load_en = 1'b0;
        unique case (r_state)
            ST_FETCH: begin
                ir_load_en = 1'b1;
                halt       = 1'b0;
            end
            ST_DECODE: begin
                if (w_is_mem_op) begin
                    data_rd_en = 1'b1;
                    data_addr  = w_operand;
                end
            end
            ST_EXEC: begin
                data_addr = w_operand;
                case (w_opcode)
                    c_op_lda: begin
                        acc_load_en = 1'b1;
                        acc_src     = 2'd1;
                    end
                    c_op_add: begin
                        acc_load_en = 1'b1;
                        alu_op      = 2'd1;
                    end
                    c_op_sub: begin
                        acc_load_en = 1'b1;
                        alu_op      = 2'd2;
                    end
                    c_op_out: out_load_en = 1'b1;
                    c_op_jmp: begin
                        jump_en   = 1'b1;
                        jump_addr = w_operand;
                    end
                    c_op_jz: begin
                        if (zero_flag) begin
                            jump_en   = 1'b1;
                            jump_addr = w_operand;
                        end
                    end
                    c_op_jc: begin
                        if (carry_flag) begin
                            jump_en   = 1'b1;
                            jump_addr = w_operand;
                        end
                    end
                    c_op_ldi: begin
                        acc_load_en = 1'b1;
                        acc_src     = 2'd2;
                    end
                    c_op_nop, c_op_hlt: ;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
